// File: rtl/nco_synth_pkg.sv
// Shared audio constants, FSM encoding and quarter-wave sine table generator.
// Used by the NCO, its sine ROM and the handshake interface.
package nco_synth_pkg;

  localparam int PHASE_W    = 24;
  localparam int LUT_ADDR_W = 8;
  localparam int ROM_DEPTH  = 1 << LUT_ADDR_W;
  localparam int ROM_W      = 9;
  localparam int ROM_MAX    = 511;
  localparam int CODE_W     = 10;
  localparam int MIDSCALE   = 512;
  localparam int VOL_W      = 3;

  localparam logic [CODE_W-1:0] MID_CODE = CODE_W'(MIDSCALE);

  typedef enum logic [1:0] {
    S_ADDR,
    S_ROM,
    S_OUT,
    S_HOLD
  } state_t;

  // round(511*sin(pi/2*(i+0.5)/256)); the half-step offset makes
  // mirrored quadrants meet without a repeated sample.
  function automatic logic [ROM_W-1:0] sine_entry(input int i);
    real x;
    real t;
    real s;
    x = 1.5707963267948966 * (real'(i) + 0.5)
        / real'(ROM_DEPTH);
    t = x;
    s = 0.0;
    for (int k = 1; k <= 10; k++) begin
      s = s + t;
      t = -t * x * x / real'((2 * k) * (2 * k + 1));
    end
    return ROM_W'($rtoi(real'(ROM_MAX) * s + 0.5));
  endfunction

endpackage

// File: rtl/nco_synth_if.sv
// Sample handshake bundle between the NCO (master) and the PWM sampler.
// Carries tone controls in, and valid/code/underrun back out.
interface nco_synth_if;
  import nco_synth_pkg::*;

  logic [PHASE_W-1:0] fcw;
  logic               note_en;
  logic [VOL_W-1:0]   volume;
  logic               synth_ready;
  logic               synth_valid;
  logic [CODE_W-1:0]  scaled_synth_code;
  logic               underrun;

  modport master (
    input  fcw,
    input  note_en,
    input  volume,
    input  synth_ready,
    output synth_valid,
    output scaled_synth_code,
    output underrun
  );

  modport slave (
    output fcw,
    output note_en,
    output volume,
    output synth_ready,
    input  synth_valid,
    input  scaled_synth_code,
    input  underrun
  );

endinterface

// File: rtl/nco_synth_rom.sv
// 256x9 quarter-wave sine ROM, synchronous read, one-cycle latency.
// Ports: clk, addr (table index), data (registered entry).
module sine_quarter_rom
  import nco_synth_pkg::*;
(
  input  logic                  clk,
  input  logic [LUT_ADDR_W-1:0] addr,
  output logic [ROM_W-1:0]      data
);

  logic [ROM_W-1:0] w_rom [ROM_DEPTH];

  // Contents are fixed at elaboration from the package generator.
  for (genvar g = 0; g < ROM_DEPTH; g++) begin : g_rom
    localparam logic [ROM_W-1:0] V = sine_entry(g);
    assign w_rom[g] = V;
  end

  always_ff @(posedge clk) begin
    data <= w_rom[addr];
  end

endmodule

// File: rtl/nco_synth.sv
// Single-voice NCO: phase accumulator, quarter-wave lookup, volume shift.
// Ports: clk, rst (sync, active-high), bus (master side of nco_synth_if).
module nco_synth
  import nco_synth_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  nco_synth_if.master   bus
);

  state_t                r_state;
  logic [PHASE_W-1:0]    r_phase;
  logic                  r_note;
  logic [VOL_W-1:0]      r_vol;
  logic [LUT_ADDR_W-1:0] r_addr;
  logic                  r_neg;
  logic                  r_valid;
  logic [CODE_W-1:0]     r_code;
  logic                  r_underrun;

  logic [1:0]            w_q;
  logic [LUT_ADDR_W-1:0] w_idx;
  logic [ROM_W-1:0]      w_rom;
  logic [ROM_W-1:0]      w_mag;
  logic [CODE_W-1:0]     w_code;

  assign w_q   = r_phase[PHASE_W-1 -: 2];
  assign w_idx = r_phase[PHASE_W-3 -: LUT_ADDR_W];
  assign w_mag = w_rom >> r_vol;

  sine_quarter_rom u_rom (
    .clk  (clk),
    .addr (r_addr),
    .data (w_rom)
  );

  always_comb begin
    w_code = MID_CODE;
    if (r_note) begin
      w_code = r_neg ? MID_CODE - CODE_W'(w_mag)
                     : MID_CODE + CODE_W'(w_mag);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_ADDR;
      r_phase    <= '0;
      r_note     <= 1'b1;
      r_vol      <= '0;
      r_addr     <= '0;
      r_neg      <= 1'b0;
      r_valid    <= 1'b0;
      r_code     <= MID_CODE;
      r_underrun <= 1'b0;
    end else begin
      if (bus.synth_ready && (r_state != S_HOLD))
        r_underrun <= 1'b1;
      unique case (r_state)
        S_ADDR: begin
          // odd quadrants run the table backwards
          r_addr  <= w_q[0] ? ~w_idx : w_idx;
          r_neg   <= w_q[1];
          r_state <= S_ROM;
        end
        S_ROM: begin
          r_state <= S_OUT;
        end
        S_OUT: begin
          r_code  <= w_code;
          r_valid <= 1'b1;
          r_state <= S_HOLD;
        end
        S_HOLD: begin
          if (bus.synth_ready) begin
            r_valid <= 1'b0;
            r_note  <= bus.note_en;
            r_vol   <= bus.volume;
            r_phase <= bus.note_en ? r_phase + bus.fcw
                                   : '0;
            r_state <= S_ADDR;
          end
        end
      endcase
    end
  end

  assign bus.synth_valid       = r_valid;
  assign bus.scaled_synth_code = r_code;
  assign bus.underrun          = r_underrun;

endmodule
